// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the MEM-stage stall controller.
package mem_stall_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;
  localparam logic [STATE_W-1:0] S_ERR  = 2'd3;

endpackage

// File: rtl/mem_stall_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (inc_i && (q_o != {W{1'b1}})) begin
      q_o <= q_o + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Freezes the front of the pipeline around multi-cycle data-memory accesses.
//
//   state  | meaning
//   IDLE   | no access in flight; a mem op in EX/MEM stalls this cycle and starts one
//   WAIT   | request held to memory until ack or timeout
//   DONE   | access completed; pipeline advances one cycle, EX/MEM op ignored
//   ERR    | memory never answered; pipeline frozen until reset
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              stall_o,
  output logic              wb_bubble_o,
  output logic              error_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               we_q;
  logic               mem_op;

  assign mem_op = MemRead_i | MemWrite_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            state    <= S_WAIT;
            we_q     <= MemWrite_i;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          // ack takes priority over an expiring timeout in the same cycle
          if (mem_ack_i) begin
            state <= S_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_ERR;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    stall_o     = 1'b0;
    wb_bubble_o = 1'b0;
    error_o     = 1'b0;
    case (state)
      S_IDLE: begin
        stall_o     = mem_op;
        wb_bubble_o = mem_op;
      end
      S_WAIT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        stall_o     = 1'b1;
        wb_bubble_o = 1'b1;
      end
      S_ERR: begin
        stall_o     = 1'b1;
        wb_bubble_o = 1'b1;
        error_o     = 1'b1;
      end
      default: ;
    endcase
  end

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_o),
    .q_o   (stall_cnt_o)
  );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed self-checking bench for mem_stall_ctrl with a short timeout and a 2-bit perf counter copy.
module tb_mem_stall_ctrl;

  logic clk = 1'b0;
  logic rst, rst_s, rd, wr, ack;

  logic        req, we, stall, bub, err;
  logic [15:0] cnt;
  logic        s_req, s_we, s_stall, s_bub, s_err;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stall_ctrl #(.TIMEOUT(4), .CNT_W(8), .PERF_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .MemRead_i   (rd),
    .MemWrite_i  (wr),
    .mem_ack_i   (ack),
    .mem_req_o   (req),
    .mem_we_o    (we),
    .stall_o     (stall),
    .wb_bubble_o (bub),
    .error_o     (err),
    .stall_cnt_o (cnt)
  );

  mem_stall_ctrl #(.TIMEOUT(4), .CNT_W(8), .PERF_W(2)) dut_s (
    .clk_i       (clk),
    .rst_i       (rst_s),
    .MemRead_i   (rd),
    .MemWrite_i  (wr),
    .mem_ack_i   (ack),
    .mem_req_o   (s_req),
    .mem_we_o    (s_we),
    .stall_o     (s_stall),
    .wb_bubble_o (s_bub),
    .error_o     (s_err),
    .stall_cnt_o (s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic e_req, input logic e_we,
                      input logic e_stall, input logic e_bub, input logic e_err);
    chk({tag, ".req"},    32'(req),   32'(e_req));
    chk({tag, ".we"},     32'(we),    32'(e_we));
    chk({tag, ".stall"},  32'(stall), 32'(e_stall));
    chk({tag, ".bubble"}, 32'(bub),   32'(e_bub));
    chk({tag, ".error"},  32'(err),   32'(e_err));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_s = 1'b1; rd = 1'b0; wr = 1'b0; ack = 1'b0;

    // reset held two cycles
    next_cycle(); next_cycle(); #1;
    outs("rst", 0, 0, 0, 0, 0);
    chk("rst.cnt", 32'(cnt), 0);
    chk("rst.s_cnt", 32'(s_cnt), 0);
    rst = 1'b0;

    // load, ack on third WAIT cycle
    next_cycle(); rd = 1'b1; #1; outs("t2.idle", 0, 0, 1, 1, 0);
    next_cycle(); #1; outs("t2.w0", 1, 0, 1, 1, 0);
    next_cycle(); #1; outs("t2.w1", 1, 0, 1, 1, 0);
    next_cycle(); ack = 1'b1; #1; outs("t2.w2", 1, 0, 1, 1, 0);
    next_cycle(); ack = 1'b0; #1; outs("t2.done", 0, 0, 0, 0, 0);
    chk("t2.cnt_done", 32'(cnt), 4);
    next_cycle(); rd = 1'b0; #1; outs("t2.idle2", 0, 0, 0, 0, 0);
    chk("t2.cnt", 32'(cnt), 4);

    // store then load back-to-back, one WAIT cycle each
    next_cycle(); wr = 1'b1; #1; outs("t3.st_idle", 0, 0, 1, 1, 0);
    next_cycle(); ack = 1'b1; #1; outs("t3.st_wait", 1, 1, 1, 1, 0);
    next_cycle(); ack = 1'b0; wr = 1'b0; rd = 1'b1; #1; outs("t3.st_done", 0, 0, 0, 0, 0);
    next_cycle(); #1; outs("t3.ld_idle", 0, 0, 1, 1, 0);
    next_cycle(); ack = 1'b1; #1; outs("t3.ld_wait", 1, 0, 1, 1, 0);
    next_cycle(); ack = 1'b0; rd = 1'b0; #1; outs("t3.ld_done", 0, 0, 0, 0, 0);
    chk("t3.cnt", 32'(cnt), 8);
    next_cycle(); #1; outs("t3.idle", 0, 0, 0, 0, 0);

    // timeout with no ack, late ack ignored, reset recovers
    next_cycle(); rd = 1'b1; #1; outs("t4.idle", 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1; outs($sformatf("t4.w%0d", i), 1, 0, 1, 1, 0);
    end
    next_cycle(); ack = 1'b1; #1; outs("t4.err0", 0, 0, 1, 1, 1);
    next_cycle(); ack = 1'b0; #1; outs("t4.err1", 0, 0, 1, 1, 1);
    chk("t4.cnt_err", 32'(cnt), 14);
    next_cycle(); rst = 1'b1; rd = 1'b0; #1; outs("t4.err_rst", 0, 0, 1, 1, 1);
    next_cycle(); rst = 1'b0; #1; outs("t4.after_rst", 0, 0, 0, 0, 0);
    chk("t4.cnt_rst", 32'(cnt), 0);

    // read+write counts as write; ack on the last allowed WAIT cycle
    next_cycle(); rd = 1'b1; wr = 1'b1; #1; outs("t5.idle", 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1; outs($sformatf("t5.w%0d", i), 1, 1, 1, 1, 0);
    end
    next_cycle(); ack = 1'b1; #1; outs("t5.w3_ack", 1, 1, 1, 1, 0);
    next_cycle(); ack = 1'b0; rd = 1'b0; wr = 1'b0; #1; outs("t5.done", 0, 0, 0, 0, 0);
    chk("t5.cnt", 32'(cnt), 5);
    next_cycle(); #1; outs("t5.idle2", 0, 0, 0, 0, 0);

    // reset mid-WAIT with ack arriving one cycle later
    next_cycle(); rd = 1'b1; #1; outs("t6.idle", 0, 0, 1, 1, 0);
    next_cycle(); rst = 1'b1; #1; outs("t6.w0_rst", 1, 0, 1, 1, 0);
    next_cycle(); rst = 1'b0; ack = 1'b1; rd = 1'b0; #1; outs("t6.ack_ignored", 0, 0, 0, 0, 0);
    chk("t6.cnt_rst", 32'(cnt), 0);
    next_cycle(); ack = 1'b0; #1; outs("t6.idle2", 0, 0, 0, 0, 0);

    // five stall cycles into a 2-bit perf counter saturate at 3
    rst_s = 1'b0; rd = 1'b1; #1;
    chk("t6s.idle_stall", 32'(s_stall), 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (i == 3) ack = 1'b1;
      #1;
      outs($sformatf("t6s.w%0d", i), 1, 0, 1, 1, 0);
      chk($sformatf("t6s.s_req%0d", i), 32'(s_req), 1);
    end
    next_cycle(); ack = 1'b0; rd = 1'b0; #1; outs("t6s.done", 0, 0, 0, 0, 0);
    chk("t6s.cnt16", 32'(cnt), 5);
    chk("t6s.cnt2", 32'(s_cnt), 3);
    chk("t6s.s_err", 32'(s_err), 0);
    chk("t6s.s_bub", 32'(s_bub), 0);
    chk("t6s.s_we", 32'(s_we), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
